pipelined_addsub: RTL and testbench

- Parametrised, pipelined add/subtract unit that generalises the team's fixed 32-bit single-cycle adder.
- Operand width and pipeline depth are configurable, and add or subtract is selected per transaction.
- It reports carry-out and signed overflow, and uses a valid/ready handshake so it can sit directly in streaming datapaths with backpressure.
- The carry chain is split into STAGES equal slices, with one register stage per slice.

---
 rtl/addsub_pkg.sv | 12 +
 rtl/pipelined_addsub_if.sv | 26 ++
 rtl/addsub_slice.sv | 20 ++
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 tb/tb_pipelined_addsub.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of one carry-chain slice; the caller guarantees exact division.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Streaming operand/result bus of the pipelined add/subtract unit.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, in1, in2, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, in1, in2, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit slice add with carry-in; also exposes the carry into the
// slice MSB so the top slice can derive signed overflow.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_c_msb
);
    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum   = w_full[W-1:0];
    assign o_cout  = w_full[W];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign o_c_msb = w_full[W-1] ^ i_a[W-1] ^ i_b[W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: carry chain cut into STAGES slices, one register stage
// per slice, with an elastic valid/ready handshake between stages.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_addsub_if.slave   bus
);
    localparam int W = slice_width(WIDTH, STAGES);

    if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be divisible by STAGES");
    end
    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_addsub: STAGES must be in 1..WIDTH");
    end

    logic             w_ready [STAGES+1];
    logic             w_valid [STAGES];
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic [WIDTH-1:0] w_sum   [STAGES];
    logic             w_carry [STAGES];
    logic             w_ovf   [STAGES];

    // Subtraction is folded in at the input: later slices only ever add.
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    assign w_b_in = (bus.op == OP_SUB) ? ~bus.in2 : bus.in2;
    assign w_c_in = (bus.op == OP_SUB) ? ~bus.cin : bus.cin;

    assign w_ready[STAGES] = bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             w_src_valid;
            logic [WIDTH-1:0] w_src_a;
            logic [WIDTH-1:0] w_src_b;
            logic [WIDTH-1:0] w_src_sum;
            logic             w_src_c;

            if (gi == 0) begin : g_head
                assign w_src_valid = bus.in_valid;
                assign w_src_a     = bus.in1;
                assign w_src_b     = w_b_in;
                assign w_src_sum   = '0;
                assign w_src_c     = w_c_in;
            end else begin : g_body
                assign w_src_valid = w_valid[gi-1];
                assign w_src_a     = w_a[gi-1];
                assign w_src_b     = w_b[gi-1];
                assign w_src_sum   = w_sum[gi-1];
                assign w_src_c     = w_carry[gi-1];
            end

            logic [W-1:0]     w_slice_sum;
            logic             w_slice_cout;
            logic             w_slice_cmsb;
            logic [WIDTH-1:0] w_sum_next;

            addsub_slice #(.W(W)) u_slice (
                .i_a     (w_src_a[gi*W +: W]),
                .i_b     (w_src_b[gi*W +: W]),
                .i_cin   (w_src_c),
                .o_sum   (w_slice_sum),
                .o_cout  (w_slice_cout),
                .o_c_msb (w_slice_cmsb)
            );

            always_comb begin
                w_sum_next             = w_src_sum;
                w_sum_next[gi*W +: W]  = w_slice_sum;
            end

            logic             r_valid;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_sum;
            logic             r_c;
            logic             r_ovf;

            // Data only moves with a valid transaction, so bubbles never disturb outputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_sum   <= '0;
                    r_c     <= 1'b0;
                    r_ovf   <= 1'b0;
                end else if (w_ready[gi]) begin
                    r_valid <= w_src_valid;
                    if (w_src_valid) begin
                        r_a   <= w_src_a;
                        r_b   <= w_src_b;
                        r_sum <= w_sum_next;
                        r_c   <= w_slice_cout;
                        r_ovf <= w_slice_cmsb ^ w_slice_cout;
                    end
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_a[gi]     = r_a;
            assign w_b[gi]     = r_b;
            assign w_sum[gi]   = r_sum;
            assign w_carry[gi] = r_c;
            assign w_ovf[gi]   = r_ovf;
            assign w_ready[gi] = !r_valid || w_ready[gi+1];
        end
    endgenerate

    assign bus.in_ready  = w_ready[0] | rst;
    assign bus.out_valid = w_valid[STAGES-1];
    assign bus.sum       = w_sum[STAGES-1];
    assign bus.cout      = w_carry[STAGES-1];
    assign bus.ovf       = w_ovf[STAGES-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed literal cases plus random streams
// compared against a plain-arithmetic reference model.
module tb_pipelined_addsub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int   errors    = 0;
    int   checks    = 0;
    int   out_count = 0;
    res_t exp_q[$];

    function automatic res_t model(logic [31:0] a, logic [31:0] b, logic c, logic op);
        res_t            r;
        longint          sa, sb, s;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        if (!op) begin
            s      = sa + sb + longint'(c);
            r.sum  = a + b + 32'(c);
            r.cout = (ua + ub + 64'(c)) > 64'hFFFF_FFFF;
        end else begin
            s      = sa - sb - longint'(c);
            r.sum  = a - b - 32'(c);
            r.cout = (ua >= ub + 64'(c));
        end
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted input is modelled, every drained output compared.
    logic prev_hold = 1'b0;
    res_t prev_out;
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'({bus.sum, bus.cout, bus.ovf}), 64'(prev_out));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum 0x%0h expected no output", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    check("model_out", 64'({bus.sum, bus.cout, bus.ovf}), 64'(e));
                    out_count++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in1, bus.in2, bus.cin, bus.op));
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out  = {bus.sum, bus.cout, bus.ovf};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_input();
        bus.in1 = $urandom;
        bus.in2 = $urandom;
        bus.cin = 1'($urandom_range(0, 1));
        bus.op  = 1'($urandom_range(0, 1));
    endtask

    // Single transaction into an empty pipe; result must appear exactly STAGES cycles later.
    task automatic directed(string name, logic [31:0] a, logic [31:0] b, logic c, logic op,
                            logic [31:0] exp_sum, logic exp_cout, logic exp_ovf);
        bus.in_valid  = 1'b1;
        bus.in1       = a;
        bus.in2       = b;
        bus.cin       = c;
        bus.op        = op;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({name, "_accept"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check({name, "_early"}, 64'(bus.out_valid), 64'd0);
        tick();
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_sum"}, 64'(bus.sum), 64'(exp_sum));
        check({name, "_cout"}, 64'(bus.cout), 64'(exp_cout));
        check({name, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  sent;
        bit  newdata;
        bit  saw_low;

        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.cin       = 1'b0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        check("reset_cout", 64'(bus.cout), 64'd0);
        check("reset_ovf", 64'(bus.ovf), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        directed("add_wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("sub_borrow", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

        // Backpressure: 10 back-to-back, downstream stalled for cycles 6-9.
        base    = out_count;
        sent    = 0;
        newdata = 1'b1;
        saw_low = 1'b0;
        for (int c = 0; c < 60 && (sent < 10 || exp_q.size() > 0); c++) begin
            bus.in_valid  = (sent < 10);
            if (newdata) rand_input();
            bus.out_ready = !(c >= 6 && c <= 9);
            @(negedge clk);
            newdata = bus.in_valid && bus.in_ready;
            if (newdata) sent++;
            if (!bus.in_ready && !bus.out_ready) saw_low = 1'b1;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_results", 64'(out_count - base), 64'd10);
        check("bp_in_ready_low", 64'(saw_low), 64'd1);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Streaming: one result per cycle after a STAGES-cycle fill.
        base = out_count;
        for (int c = 0; c < 104; c++) begin
            bus.in_valid = (c < 100);
            if (c < 100) rand_input();
            @(negedge clk);
            if (c < 100) check("stream_in_ready", 64'(bus.in_ready), 64'd1);
            check("stream_out_valid", 64'(bus.out_valid), 64'(c >= STAGES));
            tick();
        end
        bus.in_valid = 1'b0;
        check("stream_results", 64'(out_count - base), 64'd100);

        // Reset mid-flight: in-flight work dropped, outputs cleared.
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            rand_input();
            rst = (c == 2);
            @(negedge clk);
            if (c == 2) check("rst_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            check("rst_no_stale", 64'(bus.out_valid), 64'd0);
        end
        tick();
        directed("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

        repeat (2) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
